serial_add_ctrl: RTL

Bit-serial adder/subtractor controller. It time-shares one full-adder cell (sum = a^b^c, carry = majority) across an N-bit operation, processing one bit per clock, LSB first. It provides a start/busy/done handshake so upstream logic can issue N-bit add/sub requests without instantiating an N-bit ripple chain. The full-adder cell is instantiated inside this block; it is the only arithmetic resource.

---
 rtl/serial_add_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder/subtractor. One full-adder cell is time-shared across an
//   N-bit operation, one bit per clock, LSB first. A start/busy/done handshake
//   lets upstream logic issue N-bit add/sub requests.
//
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous active-high reset
//     start - request, sampled only in IDLE
//     sub   - 0: a+b+cin, 1: a-b (cin ignored)
//     a, b  - N-bit operands, sampled with an accepted start
//     cin   - carry-in for add, sampled with an accepted start
//     busy  - high while an operation is in progress
//     done  - one-cycle pulse, s/cout/ovf valid
//     s     - N-bit result, held until the next completion
//     cout  - carry out of MSB (for sub: 1 = no borrow)
//     ovf   - signed overflow (carry into MSB XOR carry out of MSB)

module serial_add_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);
    // state | meaning
    // IDLE  | waiting for start; the done-pulse cycle is also IDLE
    // RUN   | one operand bit consumed per clock, LSB first
    typedef enum logic {IDLE, RUN} state_t;

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  s_q, s_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          fa_s;
    logic          fa_c;
    logic [N-1:0]  res_shift;

    serial_add_fa u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // Sum bits enter at the MSB so that after N shifts the LSB lands at bit 0.
    always_comb begin
        res_shift        = res_q >> 1;
        res_shift[N-1]   = fa_s;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction as a + ~b + 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                res_d   = res_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB on this last bit.
                    s_d     = res_shift;
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
